// File: rtl/ins_fetch_if.sv
// Host/core-side signal bundle for the instruction fetch unit.
// The master drives program loads, run and the core's pc; the slave returns the issue signals.
interface ins_fetch_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic              run;
  logic [15:0]       pc_in;
  logic [15:0]       ins;
  logic              en_in;
  logic              en2;
  logic [ADDR_W-1:0] fetch_addr;
  logic              busy;
  logic              halted;
  logic              fault;

  modport master (
    output prog_we, prog_addr, prog_data, run, pc_in,
    input  ins, en_in, en2, fetch_addr, busy, halted, fault
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run, pc_in,
    output ins, en_in, en2, fetch_addr, busy, halted, fault
  );
endinterface

// File: rtl/ins_fetch_unit.sv
// Instruction fetch stage: host-loadable program memory, issues one instruction per slot of
// STEP_CYCLES clocks to the core, following the core's pc.
module ins_fetch_unit #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned STEP_CYCLES = 4,
  parameter logic [15:0] HALT_WORD   = 16'hFFFF
) (
  input logic       clk,
  input logic       rst,
  ins_fetch_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(STEP_CYCLES - 3);

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StHalt, StFault} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stop_q, stop_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [15:0]       ins_q, ins_d;
  logic              en2_q, en2_d;
  logic [15:0]       rdata_q;
  logic [15:0]       mem [DEPTH];

  logic pc_ok;
  logic wr_ok;
  // Full 16-bit range check; only the in-range pc is truncated to an index.
  assign pc_ok = 32'(bus.pc_in) < DEPTH;
  assign wr_ok = bus.prog_we && (state_q == StIdle) && (32'(bus.prog_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
    if (state_q == StFetch) begin
      rdata_q <= mem[fetch_addr_q];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stop_d       = stop_q;
    fetch_addr_d = fetch_addr_q;
    ins_d        = ins_q;
    en2_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        stop_d = 1'b0;
        if (bus.run) begin
          if (!pc_ok) begin
            state_d = StFault;
          end else begin
            fetch_addr_d = bus.pc_in[ADDR_W-1:0];
            state_d      = StFetch;
          end
        end
      end
      StFetch: begin
        if (!bus.run) stop_d = 1'b1;
        state_d = StIssue;
      end
      StIssue: begin
        if (!bus.run) stop_d = 1'b1;
        if (rdata_q == HALT_WORD) begin
          state_d = StHalt;
        end else begin
          ins_d   = rdata_q;
          en2_d   = 1'b1;
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!bus.run) stop_d = 1'b1;
        if (cnt_q == WAIT_LAST) begin
          // A run drop anywhere in the slot ends the program once the slot is complete.
          if (!bus.run || stop_q) begin
            state_d = StIdle;
          end else if (!pc_ok) begin
            state_d = StFault;
          end else begin
            fetch_addr_d = bus.pc_in[ADDR_W-1:0];
            state_d      = StFetch;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHalt, StFault: begin
        if (!bus.run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      stop_q       <= 1'b0;
      fetch_addr_q <= '0;
      ins_q        <= '0;
      en2_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stop_q       <= stop_d;
      fetch_addr_q <= fetch_addr_d;
      ins_q        <= ins_d;
      en2_q        <= en2_d;
    end
  end

  assign bus.ins        = ins_q;
  assign bus.en2        = en2_q;
  assign bus.fetch_addr = fetch_addr_q;
  assign bus.busy       = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWait);
  assign bus.en_in      = bus.busy;
  assign bus.halted     = (state_q == StHalt);
  assign bus.fault      = (state_q == StFault);

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Bench for ins_fetch_unit: a queue holds the instructions each slot should issue, and a small
// core model advances pc_in after each en2 strobe.
module tb_ins_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ins_fetch_if #(.ADDR_W(8)) bus ();

  ins_fetch_unit #(
    .ADDR_W(8), .DEPTH(256), .STEP_CYCLES(4), .HALT_WORD(16'hFFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_ins;
  logic        hit;
  int          cyc;

  function automatic logic [15:0] pop_exp();
    if (exp_q.size() == 0) return 16'hDEAD;
    return exp_q.pop_front();
  endfunction

  // Waits (bounded) for an en2 strobe, halt or fault; cycles counts negedges waited.
  task automatic wait_evt(output logic got, output int cycles);
    got = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      cycles++;
      got = bus.en2 | bus.halted | bus.fault;
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.run = 1'b0;
    for (int i = 0; i < 12 && (bus.busy || bus.halted || bus.fault); i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.run = 1'b0; bus.pc_in = '0;
    #1;
    vectors++;
    if (bus.ins !== 16'h0 || bus.en_in !== 1'b0 || bus.en2 !== 1'b0 || bus.fetch_addr !== 8'h0
        || bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: ins=%h en_in=%b en2=%b fa=%h busy=%b halt=%b fault=%b, want all 0",
               bus.ins, bus.en_in, bus.en2, bus.fetch_addr, bus.busy, bus.halted, bus.fault);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_program();
    load(8'd0, 16'h0400); load(8'd1, 16'h2401); load(8'd2, 16'h2402); load(8'd3, 16'hFFFF);
    exp_q.push_back(16'h0400); exp_q.push_back(16'h2401); exp_q.push_back(16'h2402);
    @(negedge clk);
    bus.pc_in = 16'd0; bus.run = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_evt(hit, cyc);
      exp_ins = pop_exp();
      vectors++;
      if (!hit || bus.en2 !== 1'b1 || bus.en_in !== 1'b1 || bus.ins !== exp_ins
          || cyc != ((s == 0) ? 3 : 4)) begin
        miscompares++;
        $display("FAIL program slot%0d: en2=%b ins=%h after %0d cycles, want en2=1 ins=%h after %0d",
                 s, bus.en2, bus.ins, cyc, exp_ins, (s == 0) ? 3 : 4);
      end
      bus.pc_in = 16'(s + 1);
    end
    wait_evt(hit, cyc);
    vectors++;
    if (bus.halted !== 1'b1 || bus.en2 !== 1'b0 || bus.en_in !== 1'b0 || bus.ins !== 16'h2402
        || cyc != 4) begin
      miscompares++;
      $display("FAIL halt: halted=%b en2=%b en_in=%b ins=%h cyc=%0d, want 1 0 0 2402 cyc=4",
               bus.halted, bus.en2, bus.en_in, bus.ins, cyc);
    end
    @(negedge clk);
    vectors++;
    if (bus.halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_hold: halted=%b with run=1, want 1", bus.halted);
    end
    bus.run = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.halted !== 1'b0 || bus.busy !== 1'b0 || bus.ins !== 16'h2402) begin
      miscompares++;
      $display("FAIL halt_exit: halted=%b busy=%b ins=%h, want 0 0 2402",
               bus.halted, bus.busy, bus.ins);
    end
  endtask

  task automatic test_range();
    load(8'd255, 16'hABCD);
    exp_q.push_back(16'h0400); exp_q.push_back(16'hABCD);
    @(negedge clk);
    bus.pc_in = 16'd0; bus.run = 1'b1;
    for (int s = 0; s < 2; s++) begin
      wait_evt(hit, cyc);
      exp_ins = pop_exp();
      vectors++;
      if (!hit || bus.en2 !== 1'b1 || bus.ins !== exp_ins || cyc != ((s == 0) ? 3 : 4)
          || bus.fetch_addr !== ((s == 0) ? 8'h00 : 8'hFF)) begin
        miscompares++;
        $display("FAIL range slot%0d: en2=%b ins=%h fa=%h cyc=%0d, want ins=%h", s, bus.en2,
                 bus.ins, bus.fetch_addr, cyc, exp_ins);
      end
      bus.pc_in = (s == 0) ? 16'h00FF : 16'h0100;
    end
    wait_evt(hit, cyc);
    vectors++;
    if (bus.fault !== 1'b1 || bus.en2 !== 1'b0 || bus.en_in !== 1'b0 || bus.busy !== 1'b0
        || bus.fetch_addr !== 8'hFF || cyc != 2) begin
      miscompares++;
      $display("FAIL fault_wait: fault=%b en2=%b en_in=%b fa=%h cyc=%0d, want 1 0 0 ff cyc=2",
               bus.fault, bus.en2, bus.en_in, bus.fetch_addr, cyc);
    end
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.fault !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_exit: fault=%b busy=%b, want 0 0", bus.fault, bus.busy);
    end
    bus.pc_in = 16'h1000; bus.run = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.fault !== 1'b1 || bus.busy !== 1'b0 || bus.fetch_addr !== 8'hFF) begin
      miscompares++;
      $display("FAIL fault_idle: fault=%b busy=%b fa=%h, want 1 0 ff",
               bus.fault, bus.busy, bus.fetch_addr);
    end
    go_idle();
  endtask

  task automatic test_write_drop();
    exp_q.push_back(16'h2401);
    @(negedge clk);
    bus.pc_in = 16'd1; bus.run = 1'b1;
    wait_evt(hit, cyc);
    exp_ins = pop_exp();
    vectors++;
    if (!hit || bus.en2 !== 1'b1 || bus.ins !== exp_ins || cyc != 3) begin
      miscompares++;
      $display("FAIL wdrop_first: en2=%b ins=%h cyc=%0d, want 1 %h 3", bus.en2, bus.ins, cyc,
               exp_ins);
    end
    bus.prog_we = 1'b1; bus.prog_addr = 8'd1; bus.prog_data = 16'h1234; bus.run = 1'b0;
    @(negedge clk);
    bus.prog_we = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.en_in !== 1'b0) begin
      miscompares++;
      $display("FAIL wdrop_idle: busy=%b en_in=%b, want 0 0", bus.busy, bus.en_in);
    end
    exp_q.push_back(16'h2401);
    bus.run = 1'b1;
    wait_evt(hit, cyc);
    exp_ins = pop_exp();
    vectors++;
    if (!hit || bus.en2 !== 1'b1 || bus.ins !== exp_ins || cyc != 3) begin
      miscompares++;
      $display("FAIL wdrop_reread: en2=%b ins=%h cyc=%0d, want 1 %h 3", bus.en2, bus.ins, cyc,
               exp_ins);
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    exp_q.push_back(16'h0400);
    @(negedge clk);
    bus.pc_in = 16'd0; bus.run = 1'b1;
    wait_evt(hit, cyc);
    exp_ins = pop_exp();
    vectors++;
    if (!hit || bus.en2 !== 1'b1 || bus.ins !== exp_ins) begin
      miscompares++;
      $display("FAIL areset_pre: en2=%b ins=%h, want 1 %h", bus.en2, bus.ins, exp_ins);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.ins !== 16'h0 || bus.en_in !== 1'b0 || bus.en2 !== 1'b0 || bus.fetch_addr !== 8'h0
        || bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.fault !== 1'b0) begin
      miscompares++;
      $display("FAIL areset: ins=%h en_in=%b en2=%b fa=%h busy=%b, want all 0",
               bus.ins, bus.en_in, bus.en2, bus.fetch_addr, bus.busy);
    end
    @(negedge clk);
    exp_q.push_back(16'h2402);
    bus.pc_in = 16'd2;
    rst = 1'b0;
    wait_evt(hit, cyc);
    exp_ins = pop_exp();
    vectors++;
    if (!hit || bus.en2 !== 1'b1 || bus.ins !== exp_ins || bus.fetch_addr !== 8'd2 || cyc != 3)
    begin
      miscompares++;
      $display("FAIL areset_restart: en2=%b ins=%h fa=%h cyc=%0d, want 1 %h 02 3",
               bus.en2, bus.ins, bus.fetch_addr, cyc, exp_ins);
    end
    go_idle();
  endtask

  task automatic test_run_drop_fetch();
    int extra;
    exp_q.push_back(16'h0400);
    @(negedge clk);
    bus.pc_in = 16'd0; bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    wait_evt(hit, cyc);
    exp_ins = pop_exp();
    vectors++;
    if (!hit || bus.en2 !== 1'b1 || bus.en_in !== 1'b1 || bus.ins !== exp_ins || cyc != 2) begin
      miscompares++;
      $display("FAIL rdrop_slot: en2=%b en_in=%b ins=%h cyc=%0d, want 1 1 %h 2",
               bus.en2, bus.en_in, bus.ins, cyc, exp_ins);
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.en2) extra++;
    end
    vectors++;
    if (extra != 0 || bus.en_in !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rdrop_idle: extra en2=%0d en_in=%b busy=%b, want 0 0 0",
               extra, bus.en_in, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_range();
    test_write_drop();
    test_async_reset();
    test_run_drop_fetch();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
